// File: rtl/main_memory_if.sv
// Cache<->memory bus: level-held read/write requests answered by a one-cycle
// ready pulse, plus a sticky protocol-error flag from the memory side.
interface main_memory_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_wen;
  logic                  mem_ren;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_ready;
  logic                  proto_err;

  modport master (
    output mem_addr, mem_data_in, mem_wen, mem_ren,
    input  mem_data_out, mem_ready, proto_err
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_wen, mem_ren,
    output mem_data_out, mem_ready, proto_err
  );
endinterface

// File: rtl/main_memory.sv
// Word-addressed backing store with configurable read/write latency; answers
// each accepted request with a single-cycle mem_ready pulse.
module main_memory #(
  parameter int    ADDR_WIDTH    = 16,
  parameter int    DATA_WIDTH    = 32,
  parameter int    BYTE_OFFSET   = 2,
  parameter int    DEPTH         = 2 ** (ADDR_WIDTH - BYTE_OFFSET),
  parameter int    READ_LATENCY  = 4,
  parameter int    WRITE_LATENCY = 4,
  parameter string INIT_FILE     = ""
) (
  input logic          clk,
  input logic          rst_n,
  main_memory_if.slave bus
);
  localparam int IDX_W   = ADDR_WIDTH - BYTE_OFFSET;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  op_write;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  proto_err_q;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  logic [IDX_W-1:0] addr_idx;
  logic [CNT_W-1:0] lat_m1;
  logic             req;
  logic             unused_offset;

  assign addr_idx      = bus.mem_addr[ADDR_WIDTH-1:BYTE_OFFSET];
  assign unused_offset = &{1'b0, bus.mem_addr[BYTE_OFFSET-1:0]};
  assign req           = bus.mem_wen | bus.mem_ren;
  // Write wins when both requests are raised together.
  assign lat_m1        = bus.mem_wen ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values; blocking would chain them in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_write    <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      data_out_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_write <= bus.mem_wen;
            idx_q    <= addr_idx;
            wdata_q  <= bus.mem_data_in;
            cnt      <= lat_m1;
            if (bus.mem_wen && bus.mem_ren) proto_err_q <= 1'b1;
            if (lat_m1 != '0) begin
              state <= BUSY;
            end else begin
              state   <= RESP;
              ready_q <= 1'b1;
              if (!bus.mem_wen) data_out_q <= mem_array[addr_idx];
            end
          end
        end
        BUSY: begin
          if (!req) begin
            // Requester withdrew before completion: drop the access.
            state       <= IDLE;
            cnt         <= '0;
            proto_err_q <= 1'b1;
          end else if (cnt == CNT_W'(1)) begin
            state   <= RESP;
            cnt     <= '0;
            ready_q <= 1'b1;
            if (!op_write) data_out_q <= mem_array[idx_q];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset on purpose; resetting it would turn
  // the RAM into a huge register file. An async reset still blocks the commit
  // because it forces the FSM out of RESP before the next edge.
  always_ff @(posedge clk) begin
    if (state == RESP && op_write) mem_array[idx_q] <= wdata_q;
  end

  assign bus.mem_ready    = ready_q;
  assign bus.mem_data_out = data_out_q;
  assign bus.proto_err    = proto_err_q;
endmodule

// File: tb/tb_main_memory.sv
// Randomized scoreboard bench for main_memory: the driver queues expected
// responses, a negedge monitor matches them against each mem_ready pulse.
module tb_main_memory;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  main_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  main_memory #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_OFFSET(2),
    .READ_LATENCY(LAT), .WRITE_LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] exp_last_read = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ready_cycle", cyc, e.due);
          if (e.is_read) begin
            check("read_data", bus.mem_data_out, e.data);
            exp_last_read = e.data;
          end else begin
            check("data_out_kept", bus.mem_data_out, exp_last_read);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        void'(sb.pop_front());
        check("missing_ready", 32'd0, 32'd1);
      end
    end
  end

  task automatic set_bus(input bit wr, input bit rd, input logic [15:0] addr, input logic [31:0] data);
    bus.mem_wen     = wr;
    bus.mem_ren     = rd;
    bus.mem_addr    = addr;
    bus.mem_data_in = data;
  endtask

  // Issue one request, hold it until ready, release after the response edge.
  task automatic do_req(input bit wr, input bit rd, input logic [15:0] addr, input logic [31:0] data);
    exp_t e;
    bit   seen;
    int   w;
    w = int'(addr >> 2);
    set_bus(wr, rd, addr, data);
    e.is_read = !wr;
    e.due     = cyc + LAT;
    e.data    = '0;
    if (wr) model[w] = data;
    else if (model.exists(w)) e.data = model[w];
    else e.data = 'x;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_ready;
    end
    if (!seen) check("req_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    set_bus(1'b0, 1'b0, addr, data);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic abort_req(input bit wr, input logic [15:0] addr, input logic [31:0] data);
    set_bus(wr, !wr, addr, data);
    @(posedge clk);
    @(posedge clk);
    #1;
    set_bus(1'b0, 1'b0, addr, data);
    idle(LAT + 3);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    set_bus(1'b0, 1'b0, '0, '0);
    exp_last_read = '0;
    #1;
    check("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("rst_data_out", bus.mem_data_out, 32'd0);
    check("rst_proto_err", {31'd0, bus.proto_err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    set_bus(1'b0, 1'b0, '0, '0);
    apply_reset();

    // Basic write/read, then offset bits ignored.
    do_req(1'b1, 1'b0, 16'h0010, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 16'h0010, 32'h0);
    do_req(1'b0, 1'b1, 16'h0013, 32'h0);

    // Seed words used below.
    do_req(1'b1, 1'b0, 16'h0040, 32'hA5A5_0040);
    do_req(1'b1, 1'b0, 16'h0200, 32'h1234_0200);

    // Write-back followed by allocate read with no idle gap.
    do_req(1'b1, 1'b0, 16'h0100, 32'hCAFE_0100);
    do_req(1'b0, 1'b1, 16'h0200, 32'h0);
    do_req(1'b0, 1'b1, 16'h0100, 32'h0);
    check("proto_err_clean", {31'd0, bus.proto_err}, 32'd0);

    // Both requests high: write wins, sticky error.
    do_req(1'b1, 1'b1, 16'h0080, 32'h0000_0001);
    check("proto_err_both", {31'd0, bus.proto_err}, 32'd1);
    do_req(1'b0, 1'b1, 16'h0080, 32'h0);
    idle(3);
    check("proto_err_sticky", {31'd0, bus.proto_err}, 32'd1);

    // Reset in the middle of a write: nothing committed, no ready.
    set_bus(1'b1, 1'b0, 16'h0040, 32'h0000_0055);
    @(posedge clk);
    @(posedge clk);
    apply_reset();
    do_req(1'b0, 1'b1, 16'h0040, 32'h0);

    // Withdrawn read and withdrawn write.
    abort_req(1'b0, 16'h0200, 32'h0);
    check("proto_err_abort", {31'd0, bus.proto_err}, 32'd1);
    abort_req(1'b1, 16'h0040, 32'h0000_0077);
    do_req(1'b0, 1'b1, 16'h0040, 32'h0);

    // Randomized traffic over a small word window.
    for (int i = 0; i < 16; i++) do_req(1'b1, 1'b0, 16'(i * 4 + 16'h0400), $urandom);
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = 16'h0400 + 16'($urandom_range(0, 15) * 4) + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) do_req(1'b1, 1'b0, a, $urandom);
      else                           do_req(1'b0, 1'b1, a, 32'h0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end

    idle(LAT + 2);
    check("queue_drained", sb.size(), 32'd0);
    apply_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
